// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch stage: architectural PC, multi-cycle imem handshake,
// squash of in-flight accesses on redirect, HALT detection.
// Optional feature macro: PC_ALIGN_CHK_EN (misaligned redirect -> align_err + HALT).
module fetch_pc_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] next_PC,
  input  logic        if_ready,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic [15:0] pc_out,
  output logic [15:0] incr_PC,
  output logic        instr_valid,
  output logic        halted,
  output logic        align_err
);

  localparam int unsigned PC_W = 16;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(2);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;
  logic            squash_q, squash_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic            redir_ok;
  logic            bad_target;
  logic [PC_W-1:0] target;

`ifdef PC_ALIGN_CHK_EN
  logic            align_q, align_d;
  assign target     = next_PC;
  assign bad_target = next_PC[0];
`else
  assign target     = next_PC & 16'hFFFE;
  assign bad_target = 1'b0;
`endif

  assign redir_ok = redirect && (state_q != S_HALT);

  // Next-state, PC update and holding-register capture
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    squash_d = squash_q;
    valid_d  = valid_q;
    halted_d = halted_q;
`ifdef PC_ALIGN_CHK_EN
    align_d  = align_q;
`endif
    if (redir_ok && bad_target) begin
      state_d  = S_HALT;
      halted_d = 1'b1;
      valid_d  = 1'b0;
`ifdef PC_ALIGN_CHK_EN
      align_d  = 1'b1;
`endif
    end else begin
      case (state_q)
        S_FETCH: begin
          if (redirect) pc_d = target;
          if (!imem_stall) begin
            if (redirect) begin
              // accepted access is stale; a same-cycle hit is simply dropped
              if (!imem_done) begin
                state_d  = S_WAIT;
                squash_d = 1'b1;
              end
            end else if (imem_done) begin
              instr_d  = imem_data;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
              state_d  = S_HOLD;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (redirect) begin
            pc_d = target;
            if (imem_done) begin
              squash_d = 1'b0;
              state_d  = S_FETCH;
            end else begin
              squash_d = 1'b1;
            end
          end else if (imem_done) begin
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = S_FETCH;
            end else begin
              instr_d  = imem_data;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
              state_d  = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc_d    = target;
            valid_d = 1'b0;
            state_d = S_FETCH;
          end else if (if_ready) begin
            valid_d = 1'b0;
            if (instr_q[15:11] == 5'b00000) begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end else begin
              pc_d    = pc_q + PC_STEP;
              state_d = S_FETCH;
            end
          end
        end
        default: begin
          state_d = S_HALT;
        end
      endcase
    end
  end

  // State and holding registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= '0;
      squash_q <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
`ifdef PC_ALIGN_CHK_EN
      align_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      squash_q <= squash_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
`ifdef PC_ALIGN_CHK_EN
      align_q  <= align_d;
`endif
    end
  end

  assign imem_rd     = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = valid_q ? instr_q : NOP_INSTR;
  assign pc_out      = pc_out_q;
  assign incr_PC     = pc_out_q + PC_STEP;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
`ifdef PC_ALIGN_CHK_EN
  assign align_err   = align_q;
`else
  assign align_err   = 1'b0;
`endif

endmodule
